// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with input synchronizer, single-byte
// holding register on a ready/valid port, and framing/overrun pulses.
//
// Handshake: the holding register presents a byte while valid=1; the
// consumer takes it on any rising clk edge where valid&ready are both 1.
// valid then clears on the next cycle unless a new byte loads on that
// same edge. data changes only when a byte loads.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_err,
  output logic       overrun,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_e;

  logic          rx_m_q, rx_s_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    sr_q, sr_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          ov_q, ov_d;
  logic          stop_ok, stop_bad;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
    end
  end

  // Frame FSM registers: state, bit-time counter, bit index, shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      sr_q    <= sr_d;
    end
  end

  // Next-state logic: mid-bit sampling of start, 8 data bits LSB first, stop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bidx_d   = bidx_q;
    sr_d     = sr_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            bidx_d  = 3'd0;
            state_d = S_DATA;
          end else begin
            // Line bounced back high before mid start bit: treat as noise.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d  = '0;
          sr_d   = {rx_s_q, sr_q[7:1]};
          bidx_d = bidx_q + 3'd1;
          if (bidx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            stop_ok = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        // A held-low break must return high before another frame can start.
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register update: consume on valid&ready, load on good stop bit.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = stop_bad;
    ov_d    = 1'b0;
    if (valid_q && ready) valid_d = 1'b0;
    if (stop_ok) begin
      if (!valid_q || ready) begin
        data_d  = sr_q;
        valid_d = 1'b1;
      end else begin
        // Holding register still full: keep the old byte, drop the new one.
        ov_d = 1'b1;
      end
    end
  end

  // Output registers: holding register and one-cycle flag pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign framing_err = fe_q;
  assign overrun     = ov_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame-level bench for uart_rx with a byte
// scoreboard and a holding-register model kept at transaction level.
module tb_uart_rx;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
  // Edges from the first edge that sees the start bit on the pin to the
  // edge that registers valid/flags: 2 synchronizer edges, 1 edge to leave
  // IDLE, then the stop bit is sampled HALF + 9 bit-times later.
  localparam int LAT  = 3 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       framing_err;
  logic       overrun;
  logic       busy;
  logic [2:0] dbg_state;

  logic [7:0] exp_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         vhi_cnt = 0;
  logic       valid_prev = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .framing_err (framing_err),
    .overrun     (overrun),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one ideal 8N1 frame; stop_bit=0 forces a framing error.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop_bit;
    repeat (CPB) tick();
  endtask

  // Monitor: scoreboard on consumption, flag counting, event latency.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) vhi_cnt++;
      if (valid && !valid_prev) check("valid_latency", cyc - start_cyc, LAT);
      if (framing_err) begin
        fe_cnt++;
        check("fe_latency", cyc - start_cyc, LAT);
      end
      if (overrun) begin
        ov_cnt++;
        check("ov_latency", cyc - start_cyc, LAT);
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) check("spurious_byte", {24'h0, data}, 32'hFFFF_FFFF);
        else check("data", {24'h0, data}, {24'h0, exp_q.pop_front()});
      end
    end
    valid_prev = valid;
  end

  initial begin
    logic [7:0] singles[4];
    logic [7:0] b;
    int fe0, ov0, ov_exp;
    logic full, r;
    singles[0] = 8'h55; singles[1] = 8'h00; singles[2] = 8'hFF; singles[3] = 8'h80;

    // Reset values.
    rst = 1'b1; rx = 1'b1; ready = 1'b0;
    repeat (3) tick();
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_fe", framing_err, 1'b0);
    check("rst_ov", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (4) tick();

    // Hold a byte, then reset in the middle of another frame.
    send_frame(8'h77, 1'b1);
    check("hold_77", data, 8'h77);
    rx = 1'b0;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (20) tick();
    check("busy_midframe", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mrst_data", data, 8'h00);
    check("mrst_valid", valid, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_fe", framing_err, 1'b0);
    check("mrst_ov", overrun, 1'b0);
    tick(); tick();
    rst = 1'b0;
    repeat (2 * CPB) tick();
    ready = 1'b1;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    tick();
    check("q_after_reset", exp_q.size(), 0);
    check("data_hold_5a", data, 8'h5A);

    // Single bytes with ready held high.
    for (int i = 0; i < 4; i++) begin
      fe0 = fe_cnt; ov0 = ov_cnt; vhi_cnt = 0;
      exp_q.push_back(singles[i]);
      send_frame(singles[i], 1'b1);
      tick();
      check("single_valid_width", vhi_cnt, 1);
      check("single_no_fe", fe_cnt, fe0);
      check("single_no_ov", ov_cnt, ov0);
      check("single_q", exp_q.size(), 0);
    end

    // Glitch shorter than half a bit.
    fe0 = fe_cnt; vhi_cnt = 0;
    rx = 1'b0;
    tick(); tick();
    rx = 1'b1;
    tick();
    check("glitch_busy_hi", busy, 1'b1);
    repeat (HALF + 1) tick();
    check("glitch_busy_lo", busy, 1'b0);
    repeat (2 * CPB) tick();
    check("glitch_no_fe", fe_cnt, fe0);
    check("glitch_no_valid", vhi_cnt, 0);

    // Framing error followed by a long break, then a good byte.
    fe0 = fe_cnt; vhi_cnt = 0;
    send_frame(8'hA5, 1'b0);
    repeat (3 * CPB) tick();
    rx = 1'b1;
    repeat (2 * CPB) tick();
    check("frame_one_fe", fe_cnt, fe0 + 1);
    check("frame_no_valid", vhi_cnt, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    tick();
    check("frame_q", exp_q.size(), 0);
    check("frame_fe_total", fe_cnt, fe0 + 1);

    // Overrun: second byte dropped while first is held.
    ready = 1'b0; ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("ovr_data", data, 8'h11);
    check("ovr_valid", valid, 1'b1);
    check("ovr_pulse", ov_cnt, ov0 + 1);
    ready = 1'b1;
    tick(); tick();
    check("ovr_drained", valid, 1'b0);
    check("ovr_data_hold", data, 8'h11);
    check("ovr_q", exp_q.size(), 0);

    // Consume and load on the same edge.
    ready = 1'b0; ov0 = ov_cnt;
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1);
    exp_q.push_back(8'h44);
    fork
      send_frame(8'h44, 1'b1);
      begin
        repeat (LAT - 1) tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
      end
    join
    check("simul_valid", valid, 1'b1);
    check("simul_data", data, 8'h44);
    check("simul_no_ov", ov_cnt, ov0);
    check("simul_q", exp_q.size(), 1);
    ready = 1'b1;
    tick(); tick();
    check("simul_drained", exp_q.size(), 0);

    // Back-to-back random stream.
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    repeat (4) tick();
    check("stream_q", exp_q.size(), 0);
    check("stream_no_fe", fe_cnt, fe0);
    check("stream_no_ov", ov_cnt, ov0);

    // Random ready per frame against a holding-register model.
    ov0 = ov_cnt; ov_exp = 0; full = 1'b0;
    for (int i = 0; i < 24; i++) begin
      r = 1'($urandom_range(0, 1));
      b = 8'($urandom_range(0, 255));
      ready = r;
      if (r) begin
        exp_q.push_back(b);
        full = 1'b0;
      end else if (full) begin
        ov_exp++;
      end else begin
        exp_q.push_back(b);
        full = 1'b1;
      end
      send_frame(b, 1'b1);
    end
    ready = 1'b1;
    repeat (4) tick();
    check("rand_q", exp_q.size(), 0);
    check("rand_ov", ov_cnt, ov0 + ov_exp);
    check("rand_no_fe", fe_cnt, fe0);
    check("rand_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the terminal link: accepts 8N1 asynchronous bytes from the host terminal (keyboard commands for the Life engine: pause/step/clear/randomize), validates start and stop bits, and presents each byte on a ready/valid port to the command decoder. It is the inbound counterpart of the terminal transmitter that streams the grid out. It has its own input synchronizer, a single-byte holding register, and framing and overrun flags.

## Interface
- CLKS_PER_BIT, default 217, clock cycles per bit (25 MHz / 115200); legal range ≥ 4
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous reset, active-high
- rx  in  1  serial line, idle high, asynchronous to clk
- data  out  8  received byte, valid when valid=1
- valid  out  1  byte available in holding register
- ready  in  1  consumer accepts byte when valid&ready
- framing_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: byte completed while holding register full and not drained
- busy  out  1  high whenever FSM is not IDLE

## Operation
- rx passes through a 2-flop synchronizer (both flops reset to 1) giving rx_s; FSM uses rx_s only.
- Counter cnt of width clog2(CLKS_PER_BIT), bit index bidx of width 3, shift register sr[7:0].
- HALF = CLKS_PER_BIT/2 (integer division).
- IDLE: cnt=0. On rx_s==0 → START.
- START: cnt increments each cycle. At cnt==HALF-1: if rx_s==0 → DATA, cnt=0, bidx=0; else → IDLE (glitch, no flag).
- DATA: at cnt==CLKS_PER_BIT-1: sr = {rx_s, sr[7:1]} (LSB first), cnt=0, bidx++; after bit 7 → STOP.
- STOP: at cnt==CLKS_PER_BIT-1: if rx_s==1 deliver sr, → IDLE; if rx_s==0 pulse framing_err, discard sr, → WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then → IDLE (a held-low break yields exactly one framing_err).
- Delivery (stop-sample cycle, registered):
  - valid==0, or valid&ready this cycle: data←sr, valid←1, no overrun.
  - valid==1 and ready==0: keep old data, drop new byte, pulse overrun.
- valid clears the cycle after valid&ready unless a new byte loads in that same cycle.
- data only changes on load; it holds its last value after consumption.

## Timing
- Reset values: data=0x00, valid=0, framing_err=0, overrun=0, busy=0, FSM=IDLE, synchronizer=1.
- Reset is honored mid-frame. The partial byte is lost. After release the FSM waits in IDLE for a fresh falling edge.
- Line-to-rx_s latency: 2 cycles.
- Start bit sampled HALF cycles after START entry. Data bit n sampled HALF+(n+1)·CLKS_PER_BIT cycles after START entry. Stop bit sampled HALF+9·CLKS_PER_BIT cycles after START entry.
- valid rises 1 cycle after the stop sample, about 9.5 bit-times plus 3 cycles after the pin edge.
- framing_err and overrun assert 1 cycle after the stop sample, for exactly 1 cycle.
- Back-to-back frames: IDLE is reached on the cycle after the stop sample. A start edge arriving in the last half of the stop bit is detected correctly.
- busy is high from the cycle after the first rx_s low through the stop sample cycle, and throughout WAIT_IDLE.

## Test plan
All scenarios use CLKS_PER_BIT=8 and ideal bit timing.
- Reset: assert rst mid-frame → all outputs 0 on the next clk edge. Resend 0x5A → data=0x5A, valid=1.
- Single byte 0x55, ready=1 → valid high for exactly 1 cycle, data=0x55, no flags. Repeat for 0x00, 0xFF, 0x80.
- Glitch: rx low for 2 cycles, then high → no valid, no framing_err, busy drops within HALF+1 cycles.
- Framing: 0xA5 with stop=0, then line held low 3 bit-times, then idle, then 0x3C → one framing_err pulse, no valid for 0xA5, then data=0x3C, valid=1.
- Overrun: ready=0, send 0x11 then 0x22 → data=0x11 throughout, one overrun pulse at the 0x22 stop. Then ready=1 → 0x11 consumed, valid=0.
- Simultaneous: hold 0x33 with ready=0, send 0x44, and raise ready exactly in the 0x44 stop-sample cycle → no overrun, valid stays 1, data=0x44 next cycle. Continuous back-to-back stream of 16 bytes, ready=1 → all received in order.
